wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register.
- Selects the write-back value (memory data or ALU result) and commits it into an 8-entry x 8-bit register file.
- Serves two combinational decode read ports, with write-through bypass.
- Supplies WB->EX forwarding data and hit flags to the execute stage, and keeps a saturating count of committed writes for debug.

---
 rtl/wb_regfile_pkg.sv | 12 +
 rtl/wb_regfile_if.sv | 39 +++
 rtl/wb_regfile_core.sv | 38 +++
 rtl/wb_regfile.sv | 76 +++++++
 tb/tb_wb_regfile.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared CPU constants: default datapath/register widths and the write-back
// source select encoding used by control, MEM/WB and the register file.
package wb_regfile_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 3;
    localparam int CPU_CNT_W  = 16;

    localparam logic WB_SEL_MEM = 1'b1;
    localparam logic WB_SEL_ALU = 1'b0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB consumer bundle: write-back inputs, decode read ports, EX forwarding
// and debug commit count. The register file is the slave end.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int CNT_W  = CPU_CNT_W
);

    logic [DATA_W-1:0] wb_mem_data;
    logic [DATA_W-1:0] wb_alu_result;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_reg_write;
    logic              wb_data_sel;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [ADDR_W-1:0] ex_src1;
    logic [ADDR_W-1:0] ex_src2;
    logic              ex_fwd_hit1;
    logic              ex_fwd_hit2;
    logic [DATA_W-1:0] wb_value;
    logic [CNT_W-1:0]  commit_cnt;

    modport slave (
        input  wb_mem_data, wb_alu_result, wb_dest, wb_reg_write, wb_data_sel,
        input  rd_addr1, rd_addr2, ex_src1, ex_src2,
        output rd_data1, rd_data2, ex_fwd_hit1, ex_fwd_hit2, wb_value, commit_cnt
    );

    modport master (
        output wb_mem_data, wb_alu_result, wb_dest, wb_reg_write, wb_data_sel,
        output rd_addr1, rd_addr2, ex_src1, ex_src2,
        input  rd_data1, rd_data2, ex_fwd_hit1, ex_fwd_hit2, wb_value, commit_cnt
    );

endinterface

// File: rtl/wb_regfile_core.sv
// Raw register storage: one write port, two combinational read ports and an
// asynchronous clear. Bypass and R0 handling live in the wrapper.
module regfile_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // NOTE: every entry is cleared on reset so a read can never return X;
    // this keeps the array in flops rather than a RAM macro, which is fine at 8 entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking so same-edge readers see the old contents.
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it,
// serves bypassed decode reads and WB->EX forwarding hits, counts commits.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = CPU_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] wb_value;
    logic              we_eff;
    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [CNT_W-1:0]  cnt;

    assign wb_value = (bus.wb_data_sel == WB_SEL_MEM) ? bus.wb_mem_data : bus.wb_alu_result;

    // A write to R0 is dropped entirely: no storage update, no bypass, no hit, no count.
    assign we_eff = rst && bus.wb_reg_write && !(ZERO_REG && (bus.wb_dest == '0));

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (we_eff),
        .waddr  (bus.wb_dest),
        .wdata  (wb_value),
        .raddr1 (bus.rd_addr1),
        .raddr2 (bus.rd_addr2),
        .rdata1 (raw1),
        .rdata2 (raw2)
    );

    // Later assignments take priority: reset, then R0, then bypass, then storage.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        rd1 = raw1;
        rd2 = raw2;
        if (we_eff && (bus.rd_addr1 == bus.wb_dest)) rd1 = wb_value;
        if (we_eff && (bus.rd_addr2 == bus.wb_dest)) rd2 = wb_value;
        if (ZERO_REG && (bus.rd_addr1 == '0)) rd1 = '0;
        if (ZERO_REG && (bus.rd_addr2 == '0)) rd2 = '0;
        if (!rst) begin
            rd1 = '0;
            rd2 = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (we_eff && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.wb_value    = wb_value;
    assign bus.rd_data1    = rd1;
    assign bus.rd_data2    = rd2;
    assign bus.ex_fwd_hit1 = we_eff && (bus.ex_src1 == bus.wb_dest);
    assign bus.ex_fwd_hit2 = we_eff && (bus.ex_src2 == bus.wb_dest);
    assign bus.commit_cnt  = cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: main instance (R0 hardwired, 16-bit count),
// an ordinary-R0 instance and a 4-bit counter instance share clock and reset.
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) ifm ();
    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) ifz ();
    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(4))  ifc ();

    wb_regfile #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (ifm)
    );
    wb_regfile #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .CNT_W(16)) dut_z0 (
        .clk (clk), .rst (rst), .bus (ifz)
    );
    wb_regfile #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .CNT_W(4)) dut_c4 (
        .clk (clk), .rst (rst), .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        ifm.wb_reg_write = 1'b1;
        ifm.wb_dest      = 3'd3;
        ifm.wb_data_sel  = 1'b0;
        ifm.wb_alu_result = 8'hAA;
        ifm.ex_src1 = 3'd3;
        ifm.ex_src2 = 3'd3;
        next_cycle();
        next_cycle();
        for (int a = 0; a < 8; a++) begin
            ifm.rd_addr1 = 3'(a);
            ifm.rd_addr2 = 3'(a);
            #1;
            checks++;
            if (ifm.rd_data1 !== 8'h00 || ifm.rd_data2 !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr=%0d got %h/%h expected 00/00", a, ifm.rd_data1, ifm.rd_data2);
            end
        end
        checks++;
        if (ifm.ex_fwd_hit1 !== 1'b0 || ifm.ex_fwd_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hits got %b/%b expected 0/0", ifm.ex_fwd_hit1, ifm.ex_fwd_hit2);
        end
        checks++;
        if (ifm.commit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d expected 0", ifm.commit_cnt);
        end
        checks++;
        if (ifm.wb_value !== 8'hAA) begin
            errors++;
            $display("FAIL reset_wb_value got %h expected aa", ifm.wb_value);
        end
        ifm.wb_reg_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ifm.rd_addr1 = 3'd3;
        next_cycle();
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_r3_after got %h expected 00", ifm.rd_data1);
        end
    endtask

    task automatic test_mux_write;
        @(negedge clk);
        ifm.wb_data_sel   = 1'b0;
        ifm.wb_alu_result = 8'h5A;
        ifm.wb_mem_data   = 8'h00;
        ifm.wb_dest       = 3'd2;
        ifm.wb_reg_write  = 1'b1;
        next_cycle();
        ifm.wb_reg_write = 1'b0;
        ifm.rd_addr1     = 3'd2;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h5A) begin
            errors++;
            $display("FAIL write_alu got %h expected 5a", ifm.rd_data1);
        end
        ifm.wb_data_sel   = 1'b1;
        ifm.wb_mem_data   = 8'hC3;
        ifm.wb_alu_result = 8'h00;
        ifm.wb_reg_write  = 1'b1;
        next_cycle();
        ifm.wb_reg_write = 1'b0;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'hC3) begin
            errors++;
            $display("FAIL write_mem got %h expected c3", ifm.rd_data1);
        end
        checks++;
        if (ifm.commit_cnt !== 16'd2) begin
            errors++;
            $display("FAIL write_cnt got %0d expected 2", ifm.commit_cnt);
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        ifm.wb_data_sel   = 1'b0;
        ifm.wb_alu_result = 8'h11;
        ifm.wb_dest       = 3'd4;
        ifm.wb_reg_write  = 1'b1;
        next_cycle();
        ifm.wb_alu_result = 8'h77;
        ifm.rd_addr1      = 3'd4;
        ifm.rd_addr2      = 3'd4;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h77 || ifm.rd_data2 !== 8'h77) begin
            errors++;
            $display("FAIL bypass got %h/%h expected 77/77", ifm.rd_data1, ifm.rd_data2);
        end
        next_cycle();
        ifm.wb_reg_write = 1'b0;
        ifm.rd_addr1     = 3'd2;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'hC3 || ifm.rd_data2 !== 8'h77) begin
            errors++;
            $display("FAIL two_ports got %h/%h expected c3/77", ifm.rd_data1, ifm.rd_data2);
        end
        checks++;
        if (ifm.commit_cnt !== 16'd4) begin
            errors++;
            $display("FAIL bypass_cnt got %0d expected 4", ifm.commit_cnt);
        end
    endtask

    task automatic test_r0;
        @(negedge clk);
        ifm.wb_data_sel   = 1'b0;
        ifm.wb_alu_result = 8'hFF;
        ifm.wb_dest       = 3'd0;
        ifm.wb_reg_write  = 1'b1;
        ifm.rd_addr1      = 3'd0;
        ifm.ex_src1       = 3'd0;
        ifz.wb_data_sel   = 1'b0;
        ifz.wb_alu_result = 8'hFF;
        ifz.wb_dest       = 3'd0;
        ifz.wb_reg_write  = 1'b1;
        ifz.rd_addr1      = 3'd0;
        ifz.ex_src1       = 3'd0;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h00 || ifm.ex_fwd_hit1 !== 1'b0) begin
            errors++;
            $display("FAIL r0_zero_same got %h hit=%b expected 00 hit=0", ifm.rd_data1, ifm.ex_fwd_hit1);
        end
        checks++;
        if (ifz.rd_data1 !== 8'hFF || ifz.ex_fwd_hit1 !== 1'b1) begin
            errors++;
            $display("FAIL r0_plain_same got %h hit=%b expected ff hit=1", ifz.rd_data1, ifz.ex_fwd_hit1);
        end
        next_cycle();
        ifm.wb_reg_write = 1'b0;
        ifz.wb_reg_write = 1'b0;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h00 || ifm.commit_cnt !== 16'd4) begin
            errors++;
            $display("FAIL r0_zero_after got %h cnt=%0d expected 00 cnt=4", ifm.rd_data1, ifm.commit_cnt);
        end
        checks++;
        if (ifz.rd_data1 !== 8'hFF || ifz.commit_cnt !== 16'd1) begin
            errors++;
            $display("FAIL r0_plain_after got %h cnt=%0d expected ff cnt=1", ifz.rd_data1, ifz.commit_cnt);
        end
    endtask

    task automatic test_forwarding;
        @(negedge clk);
        ifm.wb_data_sel  = 1'b1;
        ifm.wb_mem_data  = 8'h3C;
        ifm.wb_dest      = 3'd5;
        ifm.wb_reg_write = 1'b1;
        ifm.ex_src1      = 3'd5;
        ifm.ex_src2      = 3'd6;
        #1;
        checks++;
        if (ifm.ex_fwd_hit1 !== 1'b1 || ifm.ex_fwd_hit2 !== 1'b0 || ifm.wb_value !== 8'h3C) begin
            errors++;
            $display("FAIL fwd_hit got %b/%b val=%h expected 1/0 val=3c",
                     ifm.ex_fwd_hit1, ifm.ex_fwd_hit2, ifm.wb_value);
        end
        ifm.ex_src2 = 3'd5;
        #1;
        checks++;
        if (ifm.ex_fwd_hit2 !== 1'b1) begin
            errors++;
            $display("FAIL fwd_hit2 got %b expected 1", ifm.ex_fwd_hit2);
        end
        ifm.wb_reg_write = 1'b0;
        #1;
        checks++;
        if (ifm.ex_fwd_hit1 !== 1'b0 || ifm.ex_fwd_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL fwd_idle got %b/%b expected 0/0", ifm.ex_fwd_hit1, ifm.ex_fwd_hit2);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        ifc.wb_data_sel  = 1'b0;
        ifc.wb_dest      = 3'd1;
        ifc.wb_reg_write = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            ifc.wb_alu_result = 8'(i);
            next_cycle();
            if (i == 14) begin
                checks++;
                if (ifc.commit_cnt !== 4'd14) begin
                    errors++;
                    $display("FAIL sat_14 got %0d expected 14", ifc.commit_cnt);
                end
            end
        end
        ifc.wb_reg_write = 1'b0;
        ifc.rd_addr1     = 3'd1;
        #1;
        checks++;
        if (ifc.commit_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_20 got %0d expected 15", ifc.commit_cnt);
        end
        checks++;
        if (ifc.rd_data1 !== 8'h14) begin
            errors++;
            $display("FAIL sat_last_data got %h expected 14", ifc.rd_data1);
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        ifm.wb_data_sel   = 1'b0;
        ifm.wb_alu_result = 8'h99;
        ifm.wb_dest       = 3'd6;
        ifm.wb_reg_write  = 1'b1;
        ifm.ex_src1       = 3'd6;
        ifm.rd_addr1      = 3'd2;
        ifc.wb_reg_write  = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ifm.commit_cnt !== 16'd0 || ifc.commit_cnt !== 4'd0 || ifz.commit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_cnt got %0d/%0d/%0d expected 0/0/0",
                     ifm.commit_cnt, ifc.commit_cnt, ifz.commit_cnt);
        end
        checks++;
        if (ifm.rd_data1 !== 8'h00 || ifm.ex_fwd_hit1 !== 1'b0 || ifm.wb_value !== 8'h99) begin
            errors++;
            $display("FAIL mid_outputs got %h hit=%b val=%h expected 00 hit=0 val=99",
                     ifm.rd_data1, ifm.ex_fwd_hit1, ifm.wb_value);
        end
        ifm.wb_reg_write = 1'b0;
        ifc.wb_reg_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ifm.rd_addr1 = 3'd2;
        ifm.rd_addr2 = 3'd4;
        ifz.rd_addr1 = 3'd0;
        ifc.rd_addr1 = 3'd1;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h00 || ifm.rd_data2 !== 8'h00) begin
            errors++;
            $display("FAIL mid_cleared got %h/%h expected 00/00", ifm.rd_data1, ifm.rd_data2);
        end
        checks++;
        if (ifz.rd_data1 !== 8'h00 || ifc.rd_data1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_cleared_other got %h/%h expected 00/00", ifz.rd_data1, ifc.rd_data1);
        end
        ifm.rd_addr1 = 3'd6;
        #1;
        checks++;
        if (ifm.rd_data1 !== 8'h00 || ifm.commit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_no_partial got %h cnt=%0d expected 00 cnt=0", ifm.rd_data1, ifm.commit_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        ifm.wb_mem_data = '0; ifm.wb_alu_result = '0; ifm.wb_dest = '0;
        ifm.wb_reg_write = 1'b0; ifm.wb_data_sel = 1'b0;
        ifm.rd_addr1 = '0; ifm.rd_addr2 = '0; ifm.ex_src1 = '0; ifm.ex_src2 = '0;
        ifz.wb_mem_data = '0; ifz.wb_alu_result = '0; ifz.wb_dest = '0;
        ifz.wb_reg_write = 1'b0; ifz.wb_data_sel = 1'b0;
        ifz.rd_addr1 = '0; ifz.rd_addr2 = '0; ifz.ex_src1 = '0; ifz.ex_src2 = '0;
        ifc.wb_mem_data = '0; ifc.wb_alu_result = '0; ifc.wb_dest = '0;
        ifc.wb_reg_write = 1'b0; ifc.wb_data_sel = 1'b0;
        ifc.rd_addr1 = '0; ifc.rd_addr2 = '0; ifc.ex_src1 = '0; ifc.ex_src2 = '0;

        test_reset();
        test_mux_write();
        test_bypass();
        test_r0();
        test_forwarding();
        test_saturation();
        test_reset_midrun();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
